ram_scan_reader: RTL



---
 rtl/ram_scan_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ram_scan_reader.sv
// Walks a RAM read port address by address and holds each word for display.
// Optional zero-word skipping is enabled with `define SCAN_SKIP_ZERO_EN.
module ram_scan_reader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 3,
    parameter int TICK_DIV   = 50000000,
    parameter int RD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [DATA_W-1:0] rddata,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic [3:0]        addr_tens,
    output logic [3:0]        addr_ones,
    output logic              disp_valid
);

    localparam int DW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_SHOW  = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] dwell;
    logic [2:0]    lat;
    logic [6:0]    addr_ext;
    logic [3:0]    tens_nx;
    logic [3:0]    ones_nx;
    logic          lat_done;
    logic          dwell_done;
    logic          skip;

    assign lat_done   = (lat == 3'(RD_LATENCY - 1));
    assign dwell_done = (dwell == DW'(TICK_DIV - 1));

    // BCD of the address being captured, registered with disp_addr
    always_comb begin
        addr_ext = 7'(rdaddress);
        tens_nx  = 4'(addr_ext / 7'd10);
        ones_nx  = 4'(addr_ext % 7'd10);
    end

`ifdef SCAN_SKIP_ZERO_EN
    logic [ADDR_W-1:0] skip_cnt;

    // A full lap of zero words forces the next one to be shown
    assign skip = (rddata == '0) && (skip_cnt != '1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skip_cnt <= '0;
        end else if (enable && state == S_WAIT && lat_done) begin
            if (skip)
                skip_cnt <= skip_cnt + 1'b1;
            else
                skip_cnt <= '0;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rdaddress  <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            addr_tens  <= '0;
            addr_ones  <= '0;
            disp_valid <= 1'b0;
            dwell      <= '0;
            lat        <= '0;
        end else if (state != S_IDLE && !enable) begin
            state      <= S_IDLE;
            disp_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enable)
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    lat   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!lat_done) begin
                        lat <= lat + 3'd1;
                    end else if (skip) begin
                        rdaddress <= rdaddress + 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        disp_data  <= rddata;
                        disp_addr  <= rdaddress;
                        addr_tens  <= tens_nx;
                        addr_ones  <= ones_nx;
                        disp_valid <= 1'b1;
                        dwell      <= '0;
                        state      <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (dwell_done || step) begin
                        rdaddress <= rdaddress + 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
